// File: rtl/i2c_txn_sched.sv
// Round-robin two-requester register transaction scheduler for the I2C byte engine.
// Optional timeout/error path is built when I2C_TXN_SCHED_TIMEOUT_EN is defined.
module i2c_txn_sched #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic       a_rnw,
  input  logic [6:0] a_dev,
  input  logic [7:0] a_reg,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  output logic       a_err,
  input  logic       b_req,
  input  logic       b_rnw,
  input  logic [6:0] b_dev,
  input  logic [7:0] b_reg,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic       b_err,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       core_wr_req,
  output logic       core_rd_req,
  output logic [7:0] core_wr_data,
  input  logic [7:0] core_rd_data,
  input  logic       core_wr_done,
  input  logic       core_rd_done
);

  typedef enum logic [2:0] {IDLE, LOAD, DEV, REG, DATA, RDWAIT, FIN, GUARD} state_t;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_t     state, state_nxt;
  logic       wr_done_d, rd_done_d, wr_rise, rd_rise;
  logic       rnw_q, rnw_nxt, owner_q, owner_nxt, last_grant, last_nxt;
  logic [6:0] dev_q, dev_nxt;
  logic [7:0] reg_addr_q, reg_addr_nxt, wdata_q, wdata_nxt;
  logic       busy_nxt, wr_req_nxt, rd_req_nxt;
  logic [7:0] wr_data_nxt, rdata_nxt;
  logic       a_ack_nxt, b_ack_nxt, a_err_nxt, b_err_nxt;
  logic       fin_go, fin_err, to_hit;

  assign wr_rise = core_wr_done & ~wr_done_d;
  assign rd_rise = core_rd_done & ~rd_done_d;

`ifdef I2C_TXN_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] tcnt;

  assign to_hit = (state inside {DEV, REG, DATA, RDWAIT}) && (tcnt == CW'(TIMEOUT_CYC - 1));

  // Wait counter restarts on every state change so each byte gets its own budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (state_nxt != state) begin
      tcnt <= '0;
    end else if (state inside {DEV, REG, DATA, RDWAIT}) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    rnw_nxt      = rnw_q;
    dev_nxt      = dev_q;
    reg_addr_nxt = reg_addr_q;
    wdata_nxt    = wdata_q;
    owner_nxt    = owner_q;
    last_nxt     = last_grant;
    busy_nxt     = busy;
    wr_req_nxt   = core_wr_req;
    rd_req_nxt   = core_rd_req;
    wr_data_nxt  = core_wr_data;
    rdata_nxt    = rdata;
    fin_go       = 1'b0;
    fin_err      = 1'b0;
    case (state)
      IDLE: begin
        // last_grant=1 means B went last, so A wins a tie.
        if (a_req && (!b_req || last_grant)) begin
          rnw_nxt = a_rnw; dev_nxt = a_dev; reg_addr_nxt = a_reg; wdata_nxt = a_wdata;
          owner_nxt = 1'b0; last_nxt = 1'b0; busy_nxt = 1'b1; state_nxt = LOAD;
        end else if (b_req) begin
          rnw_nxt = b_rnw; dev_nxt = b_dev; reg_addr_nxt = b_reg; wdata_nxt = b_wdata;
          owner_nxt = 1'b1; last_nxt = 1'b1; busy_nxt = 1'b1; state_nxt = LOAD;
        end
      end
      LOAD: begin
        wr_data_nxt = {dev_q, 1'b0};
        wr_req_nxt  = ~rnw_q;
        rd_req_nxt  = rnw_q;
        state_nxt   = DEV;
      end
      DEV: begin
        if (wr_rise) begin
          wr_data_nxt = reg_addr_q;
          state_nxt   = REG;
        end else if (to_hit) begin
          fin_go = 1'b1; fin_err = 1'b1;
        end
      end
      REG: begin
        if (wr_rise) begin
          if (rnw_q) begin
            state_nxt = RDWAIT;
          end else begin
            wr_data_nxt = wdata_q;
            state_nxt   = DATA;
          end
        end else if (to_hit) begin
          fin_go = 1'b1; fin_err = 1'b1;
        end
      end
      DATA: begin
        if (wr_rise) fin_go = 1'b1;
        else if (to_hit) begin
          fin_go = 1'b1; fin_err = 1'b1;
        end
      end
      RDWAIT: begin
        if (rd_rise) begin
          rdata_nxt = core_rd_data;
          fin_go    = 1'b1;
        end else if (to_hit) begin
          fin_go = 1'b1; fin_err = 1'b1;
        end
      end
      FIN:     state_nxt = GUARD;
      GUARD: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Acks and dropped engine requests are registered on FIN entry, so they are visible during FIN.
    a_ack_nxt = fin_go & ~owner_q;
    b_ack_nxt = fin_go & owner_q;
    a_err_nxt = fin_go & fin_err & ~owner_q;
    b_err_nxt = fin_go & fin_err & owner_q;
    if (fin_go) begin
      state_nxt  = FIN;
      wr_req_nxt = 1'b0;
      rd_req_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_done_d    <= 1'b0;
      rd_done_d    <= 1'b0;
      rnw_q        <= 1'b0;
      dev_q        <= '0;
      reg_addr_q   <= '0;
      wdata_q      <= '0;
      owner_q      <= 1'b0;
      last_grant   <= 1'b1;
      busy         <= 1'b0;
      core_wr_req  <= 1'b0;
      core_rd_req  <= 1'b0;
      core_wr_data <= '0;
      rdata        <= '0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_err        <= 1'b0;
      b_err        <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_done_d    <= core_wr_done;
      rd_done_d    <= core_rd_done;
      rnw_q        <= rnw_nxt;
      dev_q        <= dev_nxt;
      reg_addr_q   <= reg_addr_nxt;
      wdata_q      <= wdata_nxt;
      owner_q      <= owner_nxt;
      last_grant   <= last_nxt;
      busy         <= busy_nxt;
      core_wr_req  <= wr_req_nxt;
      core_rd_req  <= rd_req_nxt;
      core_wr_data <= wr_data_nxt;
      rdata        <= rdata_nxt;
      a_ack        <= a_ack_nxt;
      b_ack        <= b_ack_nxt;
      a_err        <= a_err_nxt;
      b_err        <= b_err_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_txn_sched.sv
// Directed testbench for i2c_txn_sched; main instance plus a TIMEOUT_CYC=16 instance.
module tb_i2c_txn_sched;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       a_req = 0, a_rnw = 0, b_req = 0, b_rnw = 0;
  logic [6:0] a_dev = 0, b_dev = 0;
  logic [7:0] a_reg = 0, a_wdata = 0, b_reg = 0, b_wdata = 0;
  logic [7:0] core_rd_data = 0;
  logic       core_wr_done = 0, core_rd_done = 0;
  logic       a_ack, a_err, b_ack, b_err, busy, core_wr_req, core_rd_req;
  logic [7:0] rdata, core_wr_data;

  logic       t_a_req = 0;
  logic       t_a_ack, t_a_err, t_b_ack, t_b_err, t_busy, t_core_wr_req, t_core_rd_req;
  logic [7:0] t_rdata, t_core_wr_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  i2c_txn_sched #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_rnw(a_rnw), .a_dev(a_dev), .a_reg(a_reg), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err),
    .b_req(b_req), .b_rnw(b_rnw), .b_dev(b_dev), .b_reg(b_reg), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err),
    .rdata(rdata), .busy(busy),
    .core_wr_req(core_wr_req), .core_rd_req(core_rd_req), .core_wr_data(core_wr_data),
    .core_rd_data(core_rd_data), .core_wr_done(core_wr_done), .core_rd_done(core_rd_done)
  );

  i2c_txn_sched #(.TIMEOUT_CYC(16)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .a_req(t_a_req), .a_rnw(1'b1), .a_dev(7'h68), .a_reg(8'h3B), .a_wdata(8'h00),
    .a_ack(t_a_ack), .a_err(t_a_err),
    .b_req(1'b0), .b_rnw(1'b0), .b_dev(7'h00), .b_reg(8'h00), .b_wdata(8'h00),
    .b_ack(t_b_ack), .b_err(t_b_err),
    .rdata(t_rdata), .busy(t_busy),
    .core_wr_req(t_core_wr_req), .core_rd_req(t_core_rd_req), .core_wr_data(t_core_wr_data),
    .core_rd_data(8'h00), .core_wr_done(1'b0), .core_rd_done(1'b0)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_core_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = core_wr_req | core_rd_req;
    end
  endtask

  // One-cycle wr_done pulse; flags = {a_ack,a_err,b_ack,b_err} the cycle after the edge.
  task automatic wr_byte(output logic [7:0] seen, output logic [3:0] flags);
    seen = core_wr_data;
    core_wr_done = 1'b1;
    @(negedge clk);
    flags = {a_ack, a_err, b_ack, b_err};
    core_wr_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_byte(input logic [7:0] val, output logic [3:0] flags, output logic [7:0] rd_seen);
    core_rd_data = val;
    core_rd_done = 1'b1;
    @(negedge clk);
    flags = {a_ack, a_err, b_ack, b_err};
    rd_seen = rdata;
    core_rd_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic serve_write(output logic [7:0] first, output logic [3:0] flags);
    bit ok;
    logic [7:0] s1, s2;
    logic [3:0] f;
    wait_core_req(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL serve_grant: core req never rose, required 1");
    end
    wr_byte(first, f);
    wr_byte(s1, f);
    wr_byte(s2, flags);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({a_ack, a_err, b_ack, b_err, rdata, busy, core_wr_req, core_rd_req, core_wr_data} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h required 0",
               {a_ack, a_err, b_ack, b_err, rdata, busy, core_wr_req, core_rd_req, core_wr_data});
    end
    do_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({a_ack, b_ack, busy, core_wr_req, core_rd_req} !== 5'd0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %b required 00000", {a_ack, b_ack, busy, core_wr_req, core_rd_req});
    end
  endtask

  task automatic test_write();
    bit ok;
    logic [7:0] s [3];
    logic [3:0] f [3];
    logic [7:0] exp [3];
    exp = '{8'hA0, 8'h10, 8'hA5};
    a_rnw = 0; a_dev = 7'h50; a_reg = 8'h10; a_wdata = 8'hA5; a_req = 1;
    wait_core_req(ok);
    checks++;
    if (!ok || core_rd_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_req: ok=%0d rd_req=%b required ok=1 rd_req=0", ok, core_rd_req);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (core_wr_req !== 1'b1) begin
        errors++;
        $display("[TB] FAIL write_wr_req_held byte %0d: got %b required 1", k, core_wr_req);
      end
      wr_byte(s[k], f[k]);
      checks++;
      if (s[k] !== exp[k]) begin
        errors++;
        $display("[TB] FAIL write_byte%0d: got %h required %h", k, s[k], exp[k]);
      end
    end
    a_req = 0;
    checks++;
    if (f[0] !== 4'b0000 || f[1] !== 4'b0000 || f[2] !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL write_ack_flags: got %b %b %b required 0000 0000 1000", f[0], f[1], f[2]);
    end
    checks++;
    if ({a_ack, busy, core_wr_req} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL write_guard: ack/busy/wr_req got %b required 010", {a_ack, busy, core_wr_req});
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_read();
    bit ok;
    logic [7:0] s0, s1, rd;
    logic [3:0] f;
    b_rnw = 1; b_dev = 7'h68; b_reg = 8'h3B; b_wdata = 8'h00; b_req = 1;
    wait_core_req(ok);
    b_dev = 7'h00; b_reg = 8'h00;
    checks++;
    if (!ok || core_rd_req !== 1'b1 || core_wr_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_req: rd=%b wr=%b required rd=1 wr=0", core_rd_req, core_wr_req);
    end
    wr_byte(s0, f);
    wr_byte(s1, f);
    checks++;
    if (s0 !== 8'hD0 || s1 !== 8'h3B) begin
      errors++;
      $display("[TB] FAIL read_bytes: got %h %h required D0 3B", s0, s1);
    end
    checks++;
    if (core_rd_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_rd_req_held: got %b required 1", core_rd_req);
    end
    rd_byte(8'h7E, f, rd);
    b_req = 0;
    checks++;
    if (f !== 4'b0010 || rd !== 8'h7E) begin
      errors++;
      $display("[TB] FAIL read_ack: flags %b rdata %h required 0010 7E", f, rd);
    end
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic [7:0] first;
    logic [3:0] f;
    do_reset();
    a_rnw = 0; a_dev = 7'h11; a_reg = 8'h01; a_wdata = 8'h01;
    b_rnw = 0; b_dev = 7'h22; b_reg = 8'h02; b_wdata = 8'h02;
    a_req = 1; b_req = 1;
    serve_write(first, f);
    a_req = 0;
    checks++;
    if (first !== 8'h22 || f !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL arb_first: dev byte %h flags %b required 22 1000", first, f);
    end
    @(negedge clk);
    a_req = 1;
    serve_write(first, f);
    b_req = 0;
    checks++;
    if (first !== 8'h44 || f !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL arb_second: dev byte %h flags %b required 44 0010", first, f);
    end
    @(negedge clk);
    b_req = 1;
    serve_write(first, f);
    a_req = 0; b_req = 0;
    checks++;
    if (first !== 8'h22 || f !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL arb_third: dev byte %h flags %b required 22 1000", first, f);
    end
    @(negedge clk);
  endtask

  task automatic test_held_done();
    bit ok;
    int acks = 0;
    logic [7:0] exp [3];
    exp = '{8'hA0, 8'h10, 8'hA5};
    a_rnw = 0; a_dev = 7'h50; a_reg = 8'h10; a_wdata = 8'hA5; a_req = 1;
    wait_core_req(ok);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (core_wr_data !== exp[k]) begin
        errors++;
        $display("[TB] FAIL held_byte%0d: got %h required %h", k, core_wr_data, exp[k]);
      end
      core_wr_done = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (a_ack) begin
          acks++;
          a_req = 0;
        end
      end
      if (k < 2) begin
        checks++;
        if (core_wr_data !== exp[k+1]) begin
          errors++;
          $display("[TB] FAIL held_single_advance%0d: got %h required %h", k, core_wr_data, exp[k+1]);
        end
      end
      core_wr_done = 1'b0;
      @(negedge clk);
      if (a_ack) acks++;
    end
    a_req = 0;
    checks++;
    if (acks != 1) begin
      errors++;
      $display("[TB] FAIL held_ack_count: got %0d required 1", acks);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok = 1'b0;
    int n = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (i == 0) t_a_req = 1;
      @(negedge clk);
      ok = t_core_rd_req;
    end
    while (n < 40 && !t_a_ack) begin
      @(negedge clk);
      n++;
    end
`ifdef I2C_TXN_SCHED_TIMEOUT_EN
    // Ack lands in FIN: 16 cycles in DEV after the first core-request cycle.
    checks++;
    if (!ok || n != 16 || t_a_ack !== 1'b1 || t_a_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_ack: cycles %0d ack %b err %b required 16 1 1", n, t_a_ack, t_a_err);
    end
    checks++;
    if (t_rdata !== 8'h00 || t_b_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_rdata: rdata %h b_ack %b required 00 0", t_rdata, t_b_ack);
    end
    t_a_req = 0;
    repeat (3) @(negedge clk);
`else
    checks++;
    if (!ok || n != 40 || t_core_rd_req !== 1'b1 || t_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL no_timeout_wait: cycles %0d rd_req %b busy %b required 40 1 1", n, t_core_rd_req, t_busy);
    end
    checks++;
    if (t_a_err !== 1'b0 || t_core_wr_data !== 8'hD0) begin
      errors++;
      $display("[TB] FAIL no_timeout_state: err %b data %h required 0 D0", t_a_err, t_core_wr_data);
    end
    t_a_req = 0;
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen = 0;
    logic [7:0] s;
    logic [3:0] f;
    a_rnw = 0; a_dev = 7'h50; a_reg = 8'h10; a_wdata = 8'hA5; a_req = 1;
    wait_core_req(ok);
    wr_byte(s, f);
    #2;
    rst_n = 1'b0;
    a_req = 0;
    #1;
    checks++;
    if ({core_wr_req, core_rd_req, busy, a_ack, b_ack, t_busy} !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_async: got %b required 000000",
               {core_wr_req, core_rd_req, busy, a_ack, b_ack, t_busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_ack | b_ack | busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_no_ack: active cycles %0d required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_arbitration();
    test_held_done();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
